// File: rtl/qam_tx_pkg.sv
// qam_tx_pkg: shared states and default constants for the QAM-16 transmit sequencer
package qam_tx_pkg;
  localparam int SPS = 11;
  localparam int NTAPS = 32;
  localparam int COEF_W = 12;
  localparam int SET_W = 4;
  localparam int FLUSH_CYC = 32;
  localparam int PH_W = $clog2(SPS);
  typedef enum logic [2:0] {IDLE, LOAD, SWITCH, RUN, DRAIN} state_t;
endpackage

// File: rtl/sym_timer.sv
// sym_timer: mod-SPS symbol phase counter
//   clk, reset : clock, async active-high reset
//   en         : advance phase this cycle
//   clr        : force phase to 0 (wins over en)
//   cnt        : current phase 0..SPS-1
//   wrap       : en while cnt==SPS-1, i.e. the phase returns to 0 next cycle
module sym_timer #(
  parameter int SPS = qam_tx_pkg::SPS,
  parameter int W = qam_tx_pkg::PH_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         wrap
);
  assign wrap = en && cnt == W'(SPS - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else cnt <= clr ? '0 : wrap ? '0 : en ? cnt + W'(1) : cnt;
endmodule

// File: rtl/qam_tx_ctrl.sv
// qam_tx_ctrl: QAM-16 transmit sequencer (FIR coefficient reload, set switch, run/drain control)
//   load_req/load_set : start loading NTAPS coefficients into set load_set
//   run_req/stop_req  : start / stop symbol generation
//   cfg_valid/cfg_data/cfg_ready : coefficient beat handshake
//   coefi/coefi_valid/coef_sel/coef_on : FIR reload port, coef_on activates coef_sel
//   active_set        : currently active coefficient set
//   sym_cnt/sym_strobe/tx_en : symbol phase, new-symbol strobe, generator enable
//   busy/load_err     : not idle / load_req rejected
module qam_tx_ctrl #(
  parameter int SPS = qam_tx_pkg::SPS,
  parameter int NTAPS = qam_tx_pkg::NTAPS,
  parameter int COEF_W = qam_tx_pkg::COEF_W,
  parameter int SET_W = qam_tx_pkg::SET_W,
  parameter int FLUSH_CYC = qam_tx_pkg::FLUSH_CYC,
  localparam int PH_W = $clog2(SPS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_req,
  input  logic [SET_W-1:0]  load_set,
  input  logic              run_req,
  input  logic              stop_req,
  input  logic              cfg_valid,
  input  logic [COEF_W-1:0] cfg_data,
  output logic              cfg_ready,
  output logic [COEF_W-1:0] coefi,
  output logic              coefi_valid,
  output logic [SET_W-1:0]  coef_sel,
  output logic              coef_on,
  output logic [SET_W-1:0]  active_set,
  output logic [PH_W-1:0]   sym_cnt,
  output logic              sym_strobe,
  output logic              tx_en,
  output logic              busy,
  output logic              load_err
);
  import qam_tx_pkg::*;
  localparam int TAP_W = $clog2(NTAPS + 1);
  localparam int FL_W = $clog2(FLUSH_CYC + 1);
  state_t state, state_n;
  logic run_pend, run_pend_n;
  logic [SET_W-1:0] set_q;
  logic [TAP_W-1:0] tap_cnt;
  logic [FL_W-1:0] flush_cnt;
  logic beat, wrap, start_load;
  assign cfg_ready = state == LOAD && tap_cnt < TAP_W'(NTAPS);
  assign beat = cfg_valid && cfg_ready;
  assign start_load = state == IDLE && load_req;
  always_comb begin
    state_n = state;
    run_pend_n = run_pend;
    case (state)
      IDLE: begin
        state_n = load_req ? LOAD : run_req ? RUN : IDLE;
        run_pend_n = load_req && run_req;
      end
      LOAD: begin
        state_n = beat && tap_cnt == TAP_W'(NTAPS - 1) ? SWITCH : LOAD;
        run_pend_n = stop_req ? 1'b0 : run_req ? 1'b1 : run_pend;
      end
      SWITCH: begin
        state_n = run_pend ? RUN : IDLE;
        run_pend_n = 1'b0;
      end
      RUN: state_n = stop_req ? DRAIN : RUN;
      DRAIN: state_n = flush_cnt == FL_W'(FLUSH_CYC - 1) ? IDLE : DRAIN;
      default: state_n = IDLE;
    endcase
  end
  // Phase advances only while running and is held at 0 whenever RUN is not next,
  // so the first RUN cycle always shows phase 0 and DRAIN shows 0 throughout.
  sym_timer #(.SPS(SPS), .W(PH_W)) u_timer (
    .clk(clk),
    .reset(reset),
    .en(state == RUN),
    .clr(state_n != RUN),
    .cnt(sym_cnt),
    .wrap(wrap)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      run_pend <= 1'b0;
      set_q <= '0;
      tap_cnt <= '0;
      flush_cnt <= '0;
      coefi <= '0;
      coefi_valid <= 1'b0;
      coef_sel <= '0;
      coef_on <= 1'b0;
      active_set <= '0;
      sym_strobe <= 1'b0;
      tx_en <= 1'b0;
      busy <= 1'b0;
      load_err <= 1'b0;
    end else begin
      state <= state_n;
      run_pend <= run_pend_n;
      set_q <= start_load ? load_set : set_q;
      tap_cnt <= state == LOAD ? tap_cnt + TAP_W'(beat) : '0;
      flush_cnt <= state == DRAIN ? flush_cnt + FL_W'(1) : '0;
      coefi <= beat ? cfg_data : coefi;
      coefi_valid <= beat;
      coef_sel <= start_load ? load_set : coef_sel;
      coef_on <= state_n == SWITCH;
      active_set <= state_n == SWITCH ? set_q : active_set;
      // Strobe on RUN entry and on every phase wrap while staying in RUN.
      sym_strobe <= state_n == RUN && (state != RUN || wrap);
      tx_en <= state_n == RUN;
      busy <= state_n != IDLE;
      load_err <= load_req && (state == RUN || state == DRAIN);
    end
endmodule

// File: tb/tb_qam_tx_ctrl.sv
module tb_qam_tx_ctrl;
  logic clk = 0, reset = 1;
  logic load_req = 0, run_req = 0, stop_req = 0, cfg_valid = 0;
  logic [3:0] load_set = 0;
  logic [11:0] cfg_data = 0;
  logic cfg_ready, coefi_valid, coef_on, sym_strobe, tx_en, busy, load_err;
  logic [11:0] coefi;
  logic [3:0] coef_sel, active_set, sym_cnt;
  int nvec = 0, nerr = 0;

  qam_tx_ctrl dut (
    .clk(clk), .reset(reset), .load_req(load_req), .load_set(load_set),
    .run_req(run_req), .stop_req(stop_req), .cfg_valid(cfg_valid), .cfg_data(cfg_data),
    .cfg_ready(cfg_ready), .coefi(coefi), .coefi_valid(coefi_valid), .coef_sel(coef_sel),
    .coef_on(coef_on), .active_set(active_set), .sym_cnt(sym_cnt), .sym_strobe(sym_strobe),
    .tx_en(tx_en), .busy(busy), .load_err(load_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic run, stop, load;
    logic tx, stb;
    logic [3:0] cnt;
    logic bsy, lerr;
  } vec_t;
  vec_t tv[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string name);
    chk(name, {coefi, coefi_valid, coef_sel, coef_on, active_set, sym_cnt,
               sym_strobe, tx_en, busy, load_err, cfg_ready}, 0);
  endtask

  task automatic wait_idle(input string name, input int bound);
    int n = 0;
    while (busy && n < bound) begin
      tick;
      n++;
    end
    chk(name, busy, 0);
  endtask

  task automatic do_load(input logic [3:0] s, input logic with_run, input int nbeats);
    load_req = 1;
    load_set = s;
    run_req = with_run;
    tick;
    load_req = 0;
    run_req = 0;
    chk("load_busy", busy, 1);
    chk("load_ready", cfg_ready, 1);
    for (int k = 0; k < nbeats; k++) begin
      repeat ($urandom_range(0, 2)) begin
        cfg_valid = 0;
        tick;
        chk("gap_novalid", coefi_valid, 0);
      end
      cfg_valid = 1;
      cfg_data = 12'(k + 1);
      tick;
      chk($sformatf("beat%0d_valid", k), coefi_valid, 1);
      chk($sformatf("beat%0d_data", k), coefi, k + 1);
      chk($sformatf("beat%0d_sel", k), coef_sel, s);
    end
    cfg_valid = 0;
    if (nbeats == 32) begin
      chk("coef_on_pulse", coef_on, 1);
      chk("active_set_upd", active_set, s);
      chk("ready_dropped", cfg_ready, 0);
      tick;
      chk("coef_on_single", coef_on, 0);
      chk("post_load_tx", tx_en, with_run);
      chk("post_load_stb", sym_strobe, with_run);
      chk("post_load_busy", busy, with_run);
      chk("post_load_cnt", sym_cnt, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 1; i < 17; i++) tv[i] = '{0, 0, 0, 1, i % 11 == 0, 4'(i % 11), 1, 0};
    tv[0] = '{1, 0, 0, 1, 1, 0, 1, 0};
    tv[3] = '{0, 0, 1, 1, 0, 3, 1, 1};
    tv[17] = '{0, 1, 0, 0, 0, 0, 1, 0};
    tv[18] = '{1, 0, 0, 0, 0, 0, 1, 0};
    tv[19] = '{0, 0, 1, 0, 0, 0, 1, 1};
    repeat (2) tick;
    chk_zero("reset_outs");
    reset = 0;
    tick;
    chk_zero("idle_outs");
    for (int i = 0; i < 20; i++) begin
      run_req = tv[i].run;
      stop_req = tv[i].stop;
      load_req = tv[i].load;
      tick;
      run_req = 0;
      stop_req = 0;
      load_req = 0;
      chk($sformatf("tbl%0d_tx", i), tx_en, tv[i].tx);
      chk($sformatf("tbl%0d_stb", i), sym_strobe, tv[i].stb);
      chk($sformatf("tbl%0d_cnt", i), sym_cnt, tv[i].cnt);
      chk($sformatf("tbl%0d_busy", i), busy, tv[i].bsy);
      chk($sformatf("tbl%0d_lerr", i), load_err, tv[i].lerr);
    end
    chk("active_set_kept", active_set, 0);
    for (int j = 4; j <= 32; j++) begin
      tick;
      chk($sformatf("drain%0d_busy", j), busy, 1);
      chk($sformatf("drain%0d_tx", j), tx_en, 0);
      chk($sformatf("drain%0d_stb", j), sym_strobe, 0);
    end
    tick;
    chk("drain_done_busy", busy, 0);
    tick;
    chk("drain_run_ignored", tx_en, 0);
    do_load(4'd3, 1'b0, 32);
    chk("idle_after_load", busy, 0);
    do_load(4'd9, 1'b1, 32);
    for (int i = 1; i <= 11; i++) begin
      tick;
      chk($sformatf("run2_stb%0d", i), sym_strobe, i == 11);
    end
    stop_req = 1;
    tick;
    stop_req = 0;
    chk("stop2_tx", tx_en, 0);
    wait_idle("stop2_idle", 40);
    do_load(4'd5, 1'b0, 10);
    #2;
    reset = 1;
    #1;
    chk_zero("midload_reset_outs");
    tick;
    reset = 0;
    tick;
    chk_zero("midload_reset_idle");
    do_load(4'd7, 1'b0, 32);
    chk("reload_active", active_set, 7);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
